usart_tx_fifo: RTL and testbench

- Byte buffer between the USART receive stage and the USART transmit stage.
- Accepts one-cycle byte strobes from the receiver, stores them in a circular FIFO, and launches each byte to the transmitter with a one-cycle enable pulse.
- Launches only when the transmitter reports idle, so back-to-back received bytes are never lost or overrun on the transmit side while buffer space remains.

---
 rtl/usart_tx_fifo.sv | 134 +++++++++++++
 tb/tb_usart_tx_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/usart_tx_fifo.sv
// rtl/usart_tx_fifo.sv - circular byte FIFO feeding the USART transmitter one launch at a time
// Optional: define USART_TX_FIFO_CRLF_EN to append 8'h0A after every transmitted 8'h0D (DATA_BIT=8 only).
module usart_tx_fifo #(
  parameter int DATA_BIT  = 8,
  parameter int ADDR_W    = 4,
  parameter int BUSY_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_BIT-1:0] wr_data,
  input  logic                wr_en,
  input  logic                tx_busy,
  output logic [DATA_BIT-1:0] tx_data,
  output logic                tx_enable,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  input  logic                clr_overflow
);

  localparam int                 WAIT_W    = (BUSY_WAIT < 2) ? 1 : $clog2(BUSY_WAIT);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);
  localparam logic [ADDR_W:0]    DEPTH     = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
`ifdef USART_TX_FIFO_CRLF_EN
    , LF
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_BIT-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic                wr_ok;
  logic                pop;
`ifdef USART_TX_FIFO_CRLF_EN
  logic                lf_launch;
`endif

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  // full is the registered value, so a pop in this cycle cannot rescue a write
  assign wr_ok = wr_en && !full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pop     = 1'b0;
`ifdef USART_TX_FIFO_CRLF_EN
    lf_launch = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (count != '0 && !tx_busy) state_d = LAUNCH;
      end
      LAUNCH: begin
        pop     = 1'b1;
        wait_d  = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)                 state_d = WAIT_DONE;
        else if (wait_q == WAIT_LAST) state_d = IDLE;
        else                         wait_d  = wait_q + 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
`ifdef USART_TX_FIFO_CRLF_EN
          if (tx_data == DATA_BIT'(8'h0D)) state_d = LF;
`endif
        end
      end
`ifdef USART_TX_FIFO_CRLF_EN
      LF: begin
        lf_launch = 1'b1;
        wait_d    = '0;
        state_d   = WAIT_BUSY;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tx_data   <= '0;
      tx_enable <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full)     overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
`ifdef USART_TX_FIFO_CRLF_EN
      tx_enable <= pop || lf_launch;
      if (pop)            tx_data <= mem[rd_ptr];
      else if (lf_launch) tx_data <= DATA_BIT'(8'h0A);
`else
      tx_enable <= pop;
      if (pop) tx_data <= mem[rd_ptr];
`endif
    end
  end

endmodule

// File: tb/tb_usart_tx_fifo.sv
// tb/tb_usart_tx_fifo.sv - directed vector bench for usart_tx_fifo
module tb_usart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  int total = 0;
  int passed = 0;

  usart_tx_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .tx_busy      (tx_busy),
    .tx_data      (tx_data),
    .tx_enable    (tx_enable),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       we;
    logic [7:0] wd;
    logic       busy;
    logic       clr;
    logic       en;
    logic [7:0] data;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       ovf;
  } vec_t;

  function automatic vec_t mk(logic r, logic w, logic [7:0] d, logic b, logic c,
                              logic e, logic [7:0] td, logic [4:0] n,
                              logic em, logic fu, logic ov);
    vec_t v;
    v.rst_n = r; v.we = w; v.wd = d; v.busy = b; v.clr = c;
    v.en = e; v.data = td; v.cnt = n; v.emp = em; v.ful = fu; v.ovf = ov;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[24];

  initial begin
    // reset, single byte latency, busy timeout followed by a second launch
    vecs[0]  = mk(0,0,8'h00,0,0, 0,8'h00,0,1,0,0);
    vecs[1]  = mk(0,0,8'h00,0,0, 0,8'h00,0,1,0,0);
    vecs[2]  = mk(0,0,8'h00,0,0, 0,8'h00,0,1,0,0);
    vecs[3]  = mk(1,0,8'h00,0,0, 0,8'h00,0,1,0,0);
    vecs[4]  = mk(1,1,8'hA5,0,0, 0,8'h00,1,0,0,0);
    vecs[5]  = mk(1,0,8'h00,0,0, 0,8'h00,1,0,0,0);
    vecs[6]  = mk(1,0,8'h00,0,0, 1,8'hA5,0,1,0,0);
    vecs[7]  = mk(1,0,8'h00,0,0, 0,8'hA5,0,1,0,0);
    vecs[8]  = mk(1,0,8'h00,0,0, 0,8'hA5,0,1,0,0);
    vecs[9]  = mk(1,0,8'h00,0,0, 0,8'hA5,0,1,0,0);
    vecs[10] = mk(1,0,8'h00,0,0, 0,8'hA5,0,1,0,0);
    vecs[11] = mk(1,1,8'h3C,0,0, 0,8'hA5,1,0,0,0);
    vecs[12] = mk(1,0,8'h00,0,0, 0,8'hA5,1,0,0,0);
    vecs[13] = mk(1,0,8'h00,0,0, 1,8'h3C,0,1,0,0);
    vecs[14] = mk(1,1,8'h5A,0,0, 0,8'h3C,1,0,0,0);
    vecs[15] = mk(1,0,8'h00,0,0, 0,8'h3C,1,0,0,0);
    vecs[16] = mk(1,0,8'h00,0,0, 0,8'h3C,1,0,0,0);
    vecs[17] = mk(1,0,8'h00,0,0, 0,8'h3C,1,0,0,0);
    vecs[18] = mk(1,0,8'h00,0,0, 0,8'h3C,1,0,0,0);
    vecs[19] = mk(1,0,8'h00,0,0, 1,8'h5A,0,1,0,0);
    vecs[20] = mk(1,0,8'h00,0,0, 0,8'h5A,0,1,0,0);
    vecs[21] = mk(1,0,8'h00,0,0, 0,8'h5A,0,1,0,0);
    vecs[22] = mk(1,0,8'h00,0,0, 0,8'h5A,0,1,0,0);
    vecs[23] = mk(1,0,8'h00,0,0, 0,8'h5A,0,1,0,0);

    for (int i = 0; i < 24; i++) begin
      reset = vecs[i].rst_n; wr_en = vecs[i].we; wr_data = vecs[i].wd;
      tx_busy = vecs[i].busy; clr_overflow = vecs[i].clr;
      step();
      check($sformatf("v%0d tx_enable", i), int'(tx_enable), int'(vecs[i].en));
      check($sformatf("v%0d tx_data", i),   int'(tx_data),   int'(vecs[i].data));
      check($sformatf("v%0d count", i),     int'(count),     int'(vecs[i].cnt));
      check($sformatf("v%0d empty", i),     int'(empty),     int'(vecs[i].emp));
      check($sformatf("v%0d full", i),      int'(full),      int'(vecs[i].ful));
      check($sformatf("v%0d overflow", i),  int'(overflow),  int'(vecs[i].ovf));
    end
    wr_en = 0;

    // burst of five with a transmitter busy for 10 cycles after each launch
    begin
      int writes = 0, launches = 0, busy_left = 0;
      int exp_iter[5] = '{2, 15, 28, 41, 54};
      for (int it = 0; it < 80; it++) begin
        wr_en = (it < 5); wr_data = 8'(it + 1);
        tx_busy = (busy_left != 0);
        if (busy_left != 0) busy_left--;
        step();
        if (it < 5) writes++;
        if (tx_enable) begin
          if (launches < 5) begin
            check($sformatf("burst%0d data", launches), int'(tx_data), launches + 1);
            check($sformatf("burst%0d cycle", launches), it, exp_iter[launches]);
          end
          launches++;
          check($sformatf("burst%0d count", launches), int'(count), writes - launches);
          busy_left = 10;
        end
      end
      wr_en = 0; tx_busy = 0;
      check("burst launches", launches, 5);
      check("burst end count", int'(count), 0);
      check("burst end empty", int'(empty), 1);
    end

    // overflow while the transmitter is held busy, then drain
    begin
      int got = 0;
      tx_busy = 1;
      for (int i = 0; i < 16; i++) begin
        wr_en = 1; wr_data = 8'(8'h10 + i);
        step();
      end
      check("ovf full after 16", int'(full), 1);
      check("ovf count after 16", int'(count), 16);
      check("ovf flag after 16", int'(overflow), 0);
      wr_data = 8'hEE; step();
      check("ovf flag after 17", int'(overflow), 1);
      check("ovf count after 17", int'(count), 16);
      clr_overflow = 1; wr_data = 8'hEF; step();
      check("ovf set beats clr", int'(overflow), 1);
      wr_en = 0; step();
      check("ovf cleared", int'(overflow), 0);
      check("ovf count kept", int'(count), 16);
      clr_overflow = 0; tx_busy = 0;
      for (int c = 0; c < 200 && got < 16; c++) begin
        step();
        if (tx_enable) begin
          check($sformatf("drain%0d data", got), int'(tx_data), 8'h10 + got);
          got++;
        end
      end
      check("drain launches", got, 16);
      repeat (6) step();
      check("drain empty", int'(empty), 1);
    end

    // CR handling with busy model
    begin
      int busy_left = 0;
      logic [7:0] seq[$];
`ifdef USART_TX_FIFO_CRLF_EN
      logic [7:0] exp_seq[3] = '{8'h0D, 8'h0A, 8'h41};
`else
      logic [7:0] exp_seq[2] = '{8'h0D, 8'h41};
`endif
      for (int it = 0; it < 60; it++) begin
        wr_en = (it < 2); wr_data = (it == 0) ? 8'h0D : 8'h41;
        tx_busy = (busy_left != 0);
        if (busy_left != 0) busy_left--;
        step();
        if (tx_enable) begin
          seq.push_back(tx_data);
          if (tx_data == 8'h0A) check("crlf count at LF", int'(count), 1);
          busy_left = 10;
        end
      end
      wr_en = 0; tx_busy = 0;
      check("crlf length", seq.size(), $size(exp_seq));
      for (int k = 0; k < $size(exp_seq); k++) begin
        if (k < seq.size()) check($sformatf("crlf byte%0d", k), int'(seq[k]), int'(exp_seq[k]));
      end
      check("crlf end count", int'(count), 0);
    end

    // reset during a launch discards buffered bytes
    begin
      int ens = 0;
      repeat (6) step();
      wr_en = 1; wr_data = 8'h77; step();
      wr_data = 8'h88; step();
      wr_en = 0; step();
      check("midrst launch", int'(tx_enable), 1);
      check("midrst data", int'(tx_data), 8'h77);
      reset = 0; #1;
      check("midrst tx_enable", int'(tx_enable), 0);
      check("midrst count", int'(count), 0);
      check("midrst empty", int'(empty), 1);
      check("midrst tx_data", int'(tx_data), 0);
      step();
      reset = 1;
      for (int c = 0; c < 10; c++) begin
        step();
        if (tx_enable) ens++;
      end
      check("midrst no launch", ens, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
